// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the architectural PC, fetches one word per instruction from
// instruction memory, and hands {instruction, PC} to the next-PC/decode logic.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  output logic        o_MemReqValid,
  output logic [31:0] o_MemAddr,
  input  logic        i_MemReqReady,
  input  logic        i_MemRspValid,
  input  logic [31:0] i_MemRspData,
  output logic        o_InstValid,
  output logic [31:0] o_Instruction,
  output logic [31:0] o_Pc,
  input  logic        i_InstReady,
  input  logic [31:0] i_NextPc,
  output logic        o_Fault,
  output logic [31:0] o_FetchCount,
  output logic [1:0]  o_State
);

  // Handshakes: a transfer happens on a posedge where valid && ready are both high. The
  // producer holds valid and its payload stable until that edge and never waits on ready.
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] fetch_count;
  logic        req_fire;
  logic        rsp_take;
  logic        inst_fire;
  logic        next_pc_ok;

  assign req_fire   = (state == S_REQ) && o_MemReqValid && i_MemReqReady;
  assign rsp_take   = (state == S_WAIT) && i_MemRspValid;
  assign inst_fire  = (state == S_HOLD) && i_InstReady;
  assign next_pc_ok = (i_NextPc[1:0] == 2'b00);

  assign o_FetchCount = fetch_count;
  assign o_State      = state;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state <= S_REQ;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_REQ:   if (req_fire)  state_next = S_WAIT;
      S_WAIT:  if (rsp_take)  state_next = S_HOLD;
      S_HOLD:  if (inst_fire) state_next = next_pc_ok ? S_REQ : S_FAULT;
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_REQ;
    endcase
  end

  // Flags are decoded from the upcoming state so they line up with it; the request valid
  // therefore stays low through reset and rises one edge after reset is released.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      pc            <= RESET_PC;
      o_MemReqValid <= 1'b0;
      o_MemAddr     <= RESET_PC;
      o_InstValid   <= 1'b0;
      o_Instruction <= 32'h0000_0000;
      o_Pc          <= RESET_PC;
      o_Fault       <= 1'b0;
      fetch_count   <= 32'h0000_0000;
    end else begin
      o_MemReqValid <= (state_next == S_REQ);
      o_InstValid   <= (state_next == S_HOLD);
      o_Fault       <= (state_next == S_FAULT);
      if (rsp_take) begin
        o_Instruction <= i_MemRspData;
        o_Pc          <= pc;
      end
      if (inst_fire) begin
        fetch_count <= fetch_count + 32'd1;
        // A misaligned target is parked on the address bus for debug; PC keeps the last good value.
        o_MemAddr   <= i_NextPc;
        if (next_pc_ok) begin
          pc <= i_NextPc;
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a vector table for the basic fetch/backpressure
// flow, then hand-written sequences for stalls, faults, reset-in-flight and counter wrap.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst;
  logic        mem_req_valid;
  logic [31:0] mem_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        inst_valid;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        inst_ready;
  logic [31:0] next_pc;
  logic        fault;
  logic [31:0] fetch_count;
  logic [1:0]  state_dbg;

  int checks;
  int errors;

  instruction_fetch_unit #(.RESET_PC(32'h0040_0000)) dut (
    .i_Clk         (clk),
    .i_Rst         (rst),
    .o_MemReqValid (mem_req_valid),
    .o_MemAddr     (mem_addr),
    .i_MemReqReady (mem_req_ready),
    .i_MemRspValid (mem_rsp_valid),
    .i_MemRspData  (mem_rsp_data),
    .o_InstValid   (inst_valid),
    .o_Instruction (instruction),
    .o_Pc          (pc_out),
    .i_InstReady   (inst_ready),
    .i_NextPc      (next_pc),
    .o_Fault       (fault),
    .o_FetchCount  (fetch_count),
    .o_State       (state_dbg)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        rst;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        inst_ready;
    logic [31:0] next_pc;
    logic        exp_req_valid;
    logic [31:0] exp_addr;
    logic        exp_inst_valid;
    logic [31:0] exp_inst;
    logic [31:0] exp_pc;
    logic        exp_fault;
    logic [31:0] exp_count;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs[NVEC];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rdy, input logic rv, input logic [31:0] rd,
                       input logic ir, input logic [31:0] npc);
    rst           = r;
    mem_req_ready = rdy;
    mem_rsp_valid = rv;
    mem_rsp_data  = rd;
    inst_ready    = ir;
    next_pc       = npc;
  endtask

  task automatic chk_all(input string tag, input logic erv, input logic [31:0] ea, input logic eiv,
                         input logic [31:0] ei, input logic [31:0] ep, input logic ef,
                         input logic [31:0] ec);
    chk({tag, "_req_valid"},  {31'd0, mem_req_valid}, {31'd0, erv});
    chk({tag, "_addr"},       mem_addr,               ea);
    chk({tag, "_inst_valid"}, {31'd0, inst_valid},    {31'd0, eiv});
    chk({tag, "_inst"},       instruction,            ei);
    chk({tag, "_pc"},         pc_out,                 ep);
    chk({tag, "_fault"},      {31'd0, fault},         {31'd0, ef});
    chk({tag, "_count"},      fetch_count,            ec);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    //            rst rdy rv  rsp_data      ir  next_pc        erv exp_addr       eiv exp_inst       exp_pc         ef count
    vecs[0]  = '{1'b1,1'b0,1'b0,32'h0000_0000,1'b0,32'h0000_0000,1'b0,32'h0040_0000,1'b0,32'h0000_0000,32'h0040_0000,1'b0,32'd0};
    vecs[1]  = '{1'b0,1'b1,1'b0,32'h0000_0000,1'b1,32'h0040_0004,1'b1,32'h0040_0000,1'b0,32'h0000_0000,32'h0040_0000,1'b0,32'd0};
    vecs[2]  = '{1'b0,1'b1,1'b0,32'h0000_0000,1'b1,32'h0040_0004,1'b0,32'h0040_0000,1'b0,32'h0000_0000,32'h0040_0000,1'b0,32'd0};
    vecs[3]  = '{1'b0,1'b1,1'b1,32'h2008_0005,1'b1,32'h0040_0004,1'b0,32'h0040_0000,1'b1,32'h2008_0005,32'h0040_0000,1'b0,32'd0};
    vecs[4]  = '{1'b0,1'b1,1'b0,32'h0000_0000,1'b1,32'h0040_0004,1'b1,32'h0040_0004,1'b0,32'h2008_0005,32'h0040_0000,1'b0,32'd1};
    vecs[5]  = '{1'b0,1'b1,1'b0,32'h0000_0000,1'b0,32'h0000_0000,1'b0,32'h0040_0004,1'b0,32'h2008_0005,32'h0040_0000,1'b0,32'd1};
    vecs[6]  = '{1'b0,1'b0,1'b1,32'h0000_0013,1'b0,32'h0000_0000,1'b0,32'h0040_0004,1'b1,32'h0000_0013,32'h0040_0004,1'b0,32'd1};
    vecs[7]  = '{1'b0,1'b1,1'b0,32'h0000_0000,1'b0,32'h0040_0099,1'b0,32'h0040_0004,1'b1,32'h0000_0013,32'h0040_0004,1'b0,32'd1};
    vecs[8]  = '{1'b0,1'b1,1'b1,32'hDEAD_BEEF,1'b0,32'h1234_5670,1'b0,32'h0040_0004,1'b1,32'h0000_0013,32'h0040_0004,1'b0,32'd1};
    vecs[9]  = '{1'b0,1'b0,1'b0,32'h0000_0000,1'b0,32'h0040_0020,1'b0,32'h0040_0004,1'b1,32'h0000_0013,32'h0040_0004,1'b0,32'd1};
    vecs[10] = '{1'b0,1'b0,1'b1,32'h0BAD_F00D,1'b0,32'h0040_0101,1'b0,32'h0040_0004,1'b1,32'h0000_0013,32'h0040_0004,1'b0,32'd1};
    vecs[11] = '{1'b0,1'b1,1'b0,32'h0000_0000,1'b0,32'h0040_0020,1'b0,32'h0040_0004,1'b1,32'h0000_0013,32'h0040_0004,1'b0,32'd1};
    vecs[12] = '{1'b0,1'b0,1'b0,32'h0000_0000,1'b1,32'h0040_0020,1'b1,32'h0040_0020,1'b0,32'h0000_0013,32'h0040_0004,1'b0,32'd2};
    vecs[13] = '{1'b0,1'b0,1'b1,32'h5555_5555,1'b1,32'h0040_0103,1'b1,32'h0040_0020,1'b0,32'h0000_0013,32'h0040_0004,1'b0,32'd2};

    tick();
    tick();

    // basic fetch, then consumer backpressure with a branch target
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rst, vecs[i].req_ready, vecs[i].rsp_valid, vecs[i].rsp_data,
            vecs[i].inst_ready, vecs[i].next_pc);
      tick();
      chk_all($sformatf("v%0d", i), vecs[i].exp_req_valid, vecs[i].exp_addr, vecs[i].exp_inst_valid,
              vecs[i].exp_inst, vecs[i].exp_pc, vecs[i].exp_fault, vecs[i].exp_count);
    end

    // memory stall with a spurious response during REQ
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    chk_all("stall_rise", 1'b1, 32'h0040_0000, 1'b0, 32'h0, 32'h0040_0000, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, (i == 1), 32'hDEAD_BEEF, 1'b1, 32'h0040_0008);
      tick();
      chk_all($sformatf("stall_req%0d", i), 1'b1, 32'h0040_0000, 1'b0, 32'h0, 32'h0040_0000, 1'b0, 32'd0);
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    chk_all("stall_acc", 1'b0, 32'h0040_0000, 1'b0, 32'h0, 32'h0040_0000, 1'b0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
      chk_all($sformatf("stall_wait%0d", i), 1'b0, 32'h0040_0000, 1'b0, 32'h0, 32'h0040_0000, 1'b0, 32'd0);
    end
    drive(1'b0, 1'b0, 1'b1, 32'h8C08_0000, 1'b0, 32'h0);
    tick();
    chk_all("stall_rsp", 1'b0, 32'h0040_0000, 1'b1, 32'h8C08_0000, 32'h0040_0000, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 32'h1111_1111, 1'b0, 32'h0);
    tick();
    chk_all("stall_rsp2", 1'b0, 32'h0040_0000, 1'b1, 32'h8C08_0000, 32'h0040_0000, 1'b0, 32'd0);

    // misaligned jump target -> sticky fault
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0040_0102);
    tick();
    chk_all("fault_enter", 1'b0, 32'h0040_0102, 1'b0, 32'h8C08_0000, 32'h0040_0000, 1'b1, 32'd1);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, (i % 3 == 0), 32'h0000_0013, 1'b1, 32'h0040_0000);
      tick();
      chk($sformatf("fault_hold%0d_req_valid", i), {31'd0, mem_req_valid}, 32'd0);
      chk($sformatf("fault_hold%0d_fault", i), {31'd0, fault}, 32'd1);
    end
    chk("fault_hold_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("fault_hold_addr", mem_addr, 32'h0040_0102);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    chk_all("fault_reset", 1'b0, 32'h0040_0000, 1'b0, 32'h0, 32'h0040_0000, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    chk_all("fault_restart", 1'b1, 32'h0040_0000, 1'b0, 32'h0, 32'h0040_0000, 1'b0, 32'd0);

    // one full fetch, then reset during WAIT with a colliding response
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0001, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0040_0004);
    tick();
    chk_all("rw_fetch", 1'b1, 32'h0040_0004, 1'b0, 32'h0000_0001, 32'h0040_0000, 1'b0, 32'd1);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    chk("rw_in_wait", {30'd0, state_dbg}, 32'd1);
    drive(1'b1, 1'b0, 1'b1, 32'hCAFE_0001, 1'b1, 32'h0040_0010);
    tick();
    chk_all("rw_reset", 1'b0, 32'h0040_0000, 1'b0, 32'h0, 32'h0040_0000, 1'b0, 32'd0);
    chk("rw_reset_state", {30'd0, state_dbg}, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 32'hCAFE_0002, 1'b0, 32'h0);
    tick();
    chk_all("rw_restart", 1'b1, 32'h0040_0000, 1'b0, 32'h0, 32'h0040_0000, 1'b0, 32'd0);

    // counter wrap and top-of-address-space PC
    force dut.fetch_count = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_count;
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0013, 1'b0, 32'h0);
    tick();
    chk("wrap_preload", fetch_count, 32'hFFFF_FFFF);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    tick();
    chk_all("wrap_accept", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0000_0013, 32'h0040_0000, 1'b0, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0067, 1'b0, 32'h0);
    tick();
    chk_all("top_hold", 1'b0, 32'hFFFF_FFFC, 1'b1, 32'h0000_0067, 32'hFFFF_FFFC, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0000);
    tick();
    chk_all("top_to_zero", 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0067, 32'hFFFF_FFFC, 1'b0, 32'd1);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    chk_all("zero_acc", 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0067, 32'hFFFF_FFFC, 1'b0, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Owns the architectural program counter and fetches instructions for the single-cycle datapath.
- Issues a word read to instruction memory over a valid/ready request channel and waits a variable number of cycles for the response.
- Presents the instruction and its PC to decode/next-PC logic over a valid/ready channel.
- On acceptance, loads the next PC computed downstream (PC+4, branch or jump target) and starts the next fetch.
- This is the consumer/producer partner of the next-PC calculator: it supplies the current PC and instruction, and it sinks the computed next PC.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded by reset; must be word aligned.

Ports:
- i_Clk  input  1  clock, all state updates on posedge
- i_Rst  input  1  reset, synchronous, active-high
- o_MemReqValid  output  1  fetch request valid
- o_MemAddr  output  32  fetch byte address
- i_MemReqReady  input  1  memory accepts request this cycle
- i_MemRspValid  input  1  instruction word returned this cycle
- i_MemRspData  input  32  returned instruction word
- o_InstValid  output  1  o_Instruction/o_Pc valid for consumer
- o_Instruction  output  32  fetched instruction
- o_Pc  output  32  address of o_Instruction
- i_InstReady  input  1  consumer accepts instruction; i_NextPc valid this cycle
- i_NextPc  input  32  next PC from next-PC logic
- o_Fault  output  1  sticky misaligned-next-PC fault
- o_FetchCount  output  32  instructions accepted since reset

Behaviour:
Reset (i_Rst high at posedge, any state) sets:
- state=REQ, PC=RESET_PC
- o_MemReqValid=0, o_MemAddr=RESET_PC
- o_InstValid=0, o_Instruction=0, o_Pc=RESET_PC
- o_Fault=0, o_FetchCount=0

o_MemReqValid rises on the first cycle with i_Rst low.

States (registered; all outputs registered):
- REQ:
  - o_MemReqValid=1, o_MemAddr=PC.
  - Address and valid stay stable until i_MemReqReady=1.
  - On valid&&ready: go to WAIT and drop o_MemReqValid next cycle.
- WAIT:
  - o_MemReqValid=0.
  - On i_MemRspValid: o_Instruction<=i_MemRspData, o_Pc<=PC, o_InstValid<=1; go to HOLD.
  - Memory response latency is ≥1 cycle after acceptance and unbounded.
- HOLD:
  - o_InstValid=1; o_Instruction and o_Pc are held stable.
  - On i_InstReady:
    - o_FetchCount<=o_FetchCount+1, wrapping 32'hFFFF_FFFF->0.
    - o_InstValid<=0.
    - If i_NextPc[1:0]==0: PC<=i_NextPc, go to REQ.
    - Otherwise: go to FAULT, o_MemAddr<=i_NextPc (offending address, debug only).
- FAULT:
  - o_Fault=1, o_MemReqValid=0, o_InstValid=0.
  - Exits only via reset.

Boundary and hazard rules:
- i_MemRspValid in REQ, HOLD or FAULT is ignored, with no state or data change.
- i_InstReady outside HOLD is ignored. i_NextPc is sampled only on the HOLD acceptance edge.
- Back-to-back with zero-wait memory and an always-ready consumer takes 3 cycles per instruction: REQ accept, response, HOLD accept.
- PC arithmetic is 32-bit with no checks beyond alignment. A next PC of 32'hFFFF_FFFC is legal.
- Reset mid-WAIT abandons the outstanding fetch. The memory side is reset by the same i_Rst, so no stale response is expected. Any stale response is ignored because state is REQ.
- Reset takes priority over every other event in the same cycle.

Test Plan:
1. Reset release, i_MemReqReady=1, 1-cycle response 32'h2008_0005, i_InstReady=1, i_NextPc=32'h0040_0004:
   - o_MemAddr=32'h0040_0000 on cycle 1.
   - o_InstValid on cycle 3 with o_Pc=32'h0040_0000.
   - Next request at 32'h0040_0004 on cycle 4.
   - o_FetchCount=1.
2. Memory stall: i_MemReqReady low 4 cycles, then response 3 cycles after acceptance:
   - o_MemReqValid and o_MemAddr stay stable throughout.
   - Exactly one response is captured.
   - A spurious i_MemRspValid pulse during REQ is ignored.
3. Consumer backpressure: i_InstReady low 5 cycles in HOLD:
   - o_Instruction and o_Pc are unchanged.
   - No new request is issued.
   - Branch i_NextPc=32'h0040_0020 is sampled only on the ready cycle, and the next o_MemAddr=32'h0040_0020.
4. Jump target i_NextPc=32'h0040_0102:
   - o_Fault=1 on the next cycle and o_MemAddr=32'h0040_0102.
   - No further requests across 20 cycles.
   - Reset clears o_Fault and restarts at RESET_PC.
5. Reset asserted in WAIT with a response arriving the same cycle:
   - Response is dropped.
   - Post-reset, outputs match reset values and the fetch restarts at RESET_PC.
   - o_FetchCount=0.
6. Preload o_FetchCount near wrap by accepting 2^32-1 instructions, forced via the bench:
   - Next acceptance gives o_FetchCount=0.
   - PC 32'hFFFF_FFFC followed by i_NextPc=0 fetches address 0 with no fault.
